// File: rtl/gate_occupancy_controller.sv
// Barrier gate controller with timed motor travel, auto-close hold, obstruction
// reversal and capacity-limited occupancy counting. Optional: GATE_MANUAL_OVERRIDE_EN.
module gate_occupancy_controller #(
  parameter int CAPACITY      = 8,
  parameter int TRAVEL_CYCLES = 3,
  parameter int HOLD_CYCLES   = 4,
  localparam int CNT_W        = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic             obstruction,
`ifdef GATE_MANUAL_OVERRIDE_EN
  input  logic             force_open,
`endif
  output logic             gate_open,
  output logic             gate_close,
  output logic             motor_up,
  output logic             motor_down,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             denied
);

  localparam int TMR_MAX = (TRAVEL_CYCLES > HOLD_CYCLES) ? TRAVEL_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [CNT_W-1:0] CAP_VAL     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_d;
  logic             entry_q, exit_q;
  logic             entry_edge, exit_edge;
  logic             entry_acc, exit_acc;
  logic             gate_req;
  logic             force_w;

`ifdef GATE_MANUAL_OVERRIDE_EN
  assign force_w = force_open;
`else
  assign force_w = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request detection and acceptance
  // ---------------------------------------------------------------------------
  assign entry_edge = entry_sensor & ~entry_q;
  assign exit_edge  = exit_sensor & ~exit_q;

  // A simultaneous exit frees a slot, so a full lot can still admit an entry.
  assign exit_acc  = exit_edge;
  assign entry_acc = entry_edge &&
                     ((occupancy < CAP_VAL) || (exit_edge && (occupancy != '0)));
  assign gate_req  = entry_acc || exit_acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: edge registers reset high so a sensor already asserted when
      // reset releases is not mistaken for a fresh request.
      entry_q <= 1'b1;
      exit_q  <= 1'b1;
    end else begin
      entry_q <= entry_sensor;
      exit_q  <= exit_sensor;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy counter and denial pulse
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    occ_d = occupancy;
    if (entry_acc && !exit_acc) begin
      occ_d = occupancy + CNT_ONE;
    end else if (exit_acc && !entry_acc && (occupancy != '0)) begin
      occ_d = occupancy - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
      denied    <= 1'b0;
    end else begin
      occupancy <= occ_d;
      denied    <= entry_edge && !entry_acc;
    end
  end

  assign full = (occupancy == CAP_VAL);

  // ---------------------------------------------------------------------------
  // Gate FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLOSED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_CLOSED: begin
        if (gate_req || force_w) begin
          state_d = ST_OPENING;
          timer_d = TRAVEL_LOAD;
        end
      end

      // Travel time is fixed; requests arriving now only update the count.
      ST_OPENING: begin
        if (timer_q <= TMR_ONE) begin
          state_d = ST_OPEN;
          timer_d = HOLD_LOAD;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      // Obstruction, override and new requests all restart the hold window.
      ST_OPEN: begin
        if (gate_req || obstruction || force_w) begin
          timer_d = HOLD_LOAD;
        end else if (timer_q <= TMR_ONE) begin
          state_d = ST_CLOSING;
          timer_d = TRAVEL_LOAD;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      // Safety reversal: anything under or approaching the gate reopens it.
      ST_CLOSING: begin
        if (obstruction || gate_req || force_w) begin
          state_d = ST_OPENING;
          timer_d = TRAVEL_LOAD;
        end else if (timer_q <= TMR_ONE) begin
          state_d = ST_CLOSED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      default: begin
        state_d = ST_CLOSED;
        timer_d = '0;
      end
    endcase
  end

  assign gate_close = (state_q == ST_CLOSED);
  assign motor_up   = (state_q == ST_OPENING);
  assign gate_open  = (state_q == ST_OPEN);
  assign motor_down = (state_q == ST_CLOSING);

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_occ_bounded : assert property (@(posedge clk) disable iff (!reset)
    occupancy <= CAP_VAL);

  a_outputs_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot({gate_open, gate_close, motor_up, motor_down}));

endmodule

// File: tb/tb_gate_occupancy_controller.sv
// Scoreboard bench for gate_occupancy_controller: the stimulus queues the
// expected outputs for each cycle, a monitor pops and compares them.
module tb_gate_occupancy_controller;

  localparam int CAP   = 2;
  localparam int TRV   = 3;
  localparam int HLD   = 4;
  localparam int CNT_W = $clog2(CAP + 1);

  typedef enum {S_CLOSED, S_OPENING, S_OPEN, S_CLOSING} gst_t;

  typedef struct {
    int         step;
    logic [3:0] gate;   // {gate_open, gate_close, motor_up, motor_down}
    int         occ;
    logic       den;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             entry_sensor;
  logic             exit_sensor;
  logic             obstruction;
  logic             force_open;
  logic             gate_open;
  logic             gate_close;
  logic             motor_up;
  logic             motor_down;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             denied;

  exp_t sb[$];
  event async_ev;
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  gate_occupancy_controller #(
    .CAPACITY     (CAP),
    .TRAVEL_CYCLES(TRV),
    .HOLD_CYCLES  (HLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_sensor(entry_sensor),
    .exit_sensor (exit_sensor),
    .obstruction (obstruction),
`ifdef GATE_MANUAL_OVERRIDE_EN
    .force_open  (force_open),
`endif
    .gate_open   (gate_open),
    .gate_close  (gate_close),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .occupancy   (occupancy),
    .full        (full),
    .denied      (denied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] enc(input gst_t st);
    case (st)
      S_CLOSED:  return 4'b0100;
      S_OPENING: return 4'b0010;
      S_OPEN:    return 4'b1000;
      default:   return 4'b0001;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One clock cycle: drive inputs mid-cycle, expect outputs after the next edge.
  task automatic cyc(input logic en, input logic ex, input logic ob, input logic fo,
                     input gst_t st, input int occ, input logic den);
    exp_t e;
    @(negedge clk);
    reset        = 1'b1;
    entry_sensor = en;
    exit_sensor  = ex;
    obstruction  = ob;
    force_open   = fo;
    step++;
    e.step = step; e.gate = enc(st); e.occ = occ; e.den = den;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input gst_t st, input int occ);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, st, occ, 1'b0);
  endtask

  // Remainder of a gate cycle after the triggering edge.
  task automatic rest_of_cycle(input int occ);
    idle(2, S_OPENING, occ);
    idle(HLD, S_OPEN, occ);
    idle(TRV, S_CLOSING, occ);
    idle(1, S_CLOSED, occ);
  endtask

  // Expectation checked right away, without waiting for a clock edge.
  task automatic expect_now(input gst_t st, input int occ);
    exp_t e;
    step++;
    e.step = step; e.gate = enc(st); e.occ = occ; e.den = 1'b0;
    sb.push_back(e);
    -> async_ev;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("s%0d_gate", e.step),
              int'({gate_open, gate_close, motor_up, motor_down}), int'(e.gate));
        check($sformatf("s%0d_occupancy", e.step), int'(occupancy), e.occ);
        check($sformatf("s%0d_full", e.step), int'(full), (e.occ == CAP) ? 1 : 0);
        check($sformatf("s%0d_denied", e.step), int'(denied), int'(e.den));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    reset        = 1'b1;
    entry_sensor = 1'b1;
    exit_sensor  = 1'b0;
    obstruction  = 1'b0;
    force_open   = 1'b0;
    #1 reset = 1'b0;
    #1 expect_now(S_CLOSED, 0);

    // 1: release reset with the entry sensor already high -> no request
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_CLOSED, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_CLOSED, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, S_CLOSED, 0, 1'b0);

    // 2: single entry, full gate cycle
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_OPENING, 1, 1'b0);
    rest_of_cycle(1);

    // 3: fill to capacity, refused entry, then an exit
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_OPENING, 2, 1'b0);
    rest_of_cycle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_CLOSED, 2, 1'b1);
    idle(2, S_CLOSED, 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_OPENING, 1, 1'b0);
    rest_of_cycle(1);

    // 4: obstruction in 2nd closing cycle, then held 6 cycles while open
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_OPENING, 2, 1'b0);
    idle(2, S_OPENING, 2);
    idle(HLD, S_OPEN, 2);
    idle(2, S_CLOSING, 2);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, S_OPENING, 2, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b1, 1'b0, S_OPEN, 2, 1'b0);
    idle(3, S_OPEN, 2);
    idle(TRV, S_CLOSING, 2);
    idle(1, S_CLOSED, 2);

    // 5: simultaneous entry+exit while full, exits down to and at zero
    cyc(1'b1, 1'b1, 1'b0, 1'b0, S_OPENING, 2, 1'b0);
    rest_of_cycle(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_OPENING, 1, 1'b0);
    idle(1, S_OPENING, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_OPENING, 0, 1'b0);
    idle(HLD, S_OPEN, 0);
    idle(TRV, S_CLOSING, 0);
    idle(1, S_CLOSED, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_OPENING, 0, 1'b0);
    idle(2, S_OPENING, 0);
    idle(2, S_OPEN, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_OPEN, 0, 1'b0);   // reloads hold timer
    idle(3, S_OPEN, 0);
    idle(1, S_CLOSING, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, S_OPENING, 0, 1'b0); // request while closing
    rest_of_cycle(0);

    // 6: asynchronous reset during opening
    cyc(1'b1, 1'b0, 1'b0, 1'b0, S_OPENING, 1, 1'b0);
    idle(1, S_OPENING, 1);
    @(negedge clk);
    reset        = 1'b0;
    entry_sensor = 1'b0;
    expect_now(S_CLOSED, 0);
    idle(2, S_CLOSED, 0);

`ifdef GATE_MANUAL_OVERRIDE_EN
    // Manual override held for 10 cycles from closed
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, S_OPENING, 0, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b1, S_OPEN, 0, 1'b0);
    idle(3, S_OPEN, 0);
    idle(TRV, S_CLOSING, 0);
    idle(1, S_CLOSED, 0);
`endif

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
